poly_result_writer: RTL and testbench
=====================================

Name: poly_result_writer

Overview:
Parametrised successor of the polynomial-multiplication output stage. It collects LANES coefficient results per accepted beat and writes the packed words to the polynomial BRAM. It provides three selectable address/data orderings: natural, bit-reversed and lo/hi de-interleave. The block generates addresses internally (no external index generator) and sits between the butterfly/modmul result lanes and the BRAM write port.

Parameters:
COEF_W, 64, width of one coefficient result
LANES, 2, result lanes per beat; must be even and >=2
ADDR_W, 10, BRAM word-address width
N_WORDS, 256, beats (words) per polynomial; power of two, >=2, <=2^ADDR_W
LOG_N, 8, log2(N_WORDS)

Ports:
clk  in  1  clock; all state on the rising edge
rst_n  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; begins a polynomial transfer
mode  in  2  0=natural, 1=bit-reversed, 2=de-interleave, 3=reserved (treated as 0); sampled on start
base_addr  in  ADDR_W  first BRAM address; sampled on start
in_valid  in  1  result beat present on result
result  in  LANES*COEF_W  lane r at bits [r*COEF_W +: COEF_W]
wr_en  out  1  BRAM write strobe
wr_addr  out  ADDR_W  BRAM write address
wr_data  out  LANES*COEF_W  BRAM write data
busy  out  1  transfer in progress
done  out  1  one-cycle pulse after the final write

Behaviour:
- Reset (async, rst_n=0): FSM->IDLE; beat counter, hold buffers, wr_en, wr_addr, wr_data, busy and done all 0. Reset mid-transfer aborts with no further writes; the next start begins a fresh transfer.
- FSM states:
  - IDLE: start -> latch mode/base, beat counter k=0, busy=1 -> RUN.
  - RUN: counts accepted beats (in_valid=1); after beat N_WORDS-1 has been accepted and its last write issued -> FIN.
  - FIN: done=1 for one cycle, busy=0 -> IDLE.
- In IDLE and FIN, in_valid is ignored. A start while busy=1 is ignored. start and in_valid in the same IDLE cycle: start is taken, the beat is dropped.
- Natural mode: a beat accepted at cycle t gives wr_en=1 at t+1 with wr_addr=base+k and wr_data=result.
- Bit-reversed mode: same timing and data; wr_addr = base + bitrev_LOG_N(k).
- De-interleave mode (H=LANES/2 lanes per half):
  - Beat 2j is held in a buffer; no write issued for it.
  - Beat 2j+1 accepted at cycle t produces two writes:
    - At t+1: wr_addr=base+j, wr_data={beat(2j+1) lanes[H-1:0], beat(2j) lanes[H-1:0]} (odd beat in the upper half).
    - At t+2: wr_addr=base+N_WORDS/2+j, wr_data={beat(2j+1) lanes[LANES-1:H], beat(2j) lanes[LANES-1:H]}.
  - If a beat arrives at t+1 it is buffered normally. No write collision is possible, since the next pair completes at >=t+2 and writes at >=t+3.
- Address arithmetic is modulo 2^ADDR_W; it wraps silently.
- wr_en is high only on the write cycles listed above. wr_addr and wr_data hold their last values when wr_en=0.
- done asserts exactly one cycle after the final wr_en, in every mode. Between start and done there are exactly N_WORDS writes.
- in_valid gaps of any length are allowed; no timeout.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles while toggling clk, start and in_valid -> wr_en=busy=done=0 throughout. Assert rst_n=0 mid-RUN at beat 100 -> wr_en drops immediately, and no write or done occurs afterwards.
- Natural, N_WORDS=256, base=0x100, result=k on every lane, back-to-back in_valid -> 256 writes at 0x100..0x1FF one cycle after each beat; done 1 cycle after the last write; busy high for exactly 258 cycles after start.
- Bit-reversed, base=0, same stimulus -> beat 1 writes addr 0x080, beat 2 writes 0x040, beat 255 writes 0x0FF.
- De-interleave, LANES=2, base=0, beat k = {hi=0xB000+k, lo=0xA000+k}:
  - Pair (0,1) -> addr 0 gets {0xA001,0xA000}; addr 128 gets {0xB001,0xB000} on the next cycle.
  - Pair (254,255) -> addr 127 and addr 255.
- Random in_valid gaps (30% duty) in de-interleave mode -> the address/data sequence is identical to the back-to-back run and never more than one write per cycle. start pulsed while busy -> no restart.
- Wrap: base=0x3F0, natural mode -> the beat-16 write lands at address 0x000.

Source files
------------

// File: rtl/poly_result_writer.sv
// Polynomial multiplication output stage: packs LANES coefficient results per beat
// and writes them to BRAM in natural, bit-reversed or lo/hi de-interleaved order.
module poly_result_writer #(
    parameter int COEF_W  = 64,
    parameter int LANES   = 2,
    parameter int ADDR_W  = 10,
    parameter int N_WORDS = 256,
    parameter int LOG_N   = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [1:0]              mode,
    input  logic [ADDR_W-1:0]       base_addr,
    input  logic                    in_valid,
    input  logic [LANES*COEF_W-1:0] result,
    output logic                    wr_en,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic [LANES*COEF_W-1:0] wr_data,
    output logic                    busy,
    output logic                    done
);
    localparam int DW = LANES * COEF_W;
    localparam int HW = DW / 2;
    localparam logic [ADDR_W-1:0] HALF = ADDR_W'(N_WORDS / 2);
    localparam logic [LOG_N-1:0]  LAST = LOG_N'(N_WORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    typedef enum logic [1:0] {ORD_NAT, ORD_REV, ORD_DEI} order_t;

    state_t              state, state_nxt;
    order_t              order;
    logic [ADDR_W-1:0]   base;
    logic [LOG_N-1:0]    k;
    logic                last_seen;
    logic                pend;
    logic [DW-1:0]       hold;
    logic [DW-1:0]       pend_data;
    logic [ADDR_W-1:0]   pend_addr;
    logic                accept;
    logic [ADDR_W-1:0]   seq_addr;
    logic [ADDR_W-1:0]   pair_addr;

    function automatic logic [LOG_N-1:0] bitrev(input logic [LOG_N-1:0] v);
        logic [LOG_N-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < LOG_N; i++) r[i] = v[LOG_N-1-i];
        return r;
    endfunction

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            // leave only once the final beat and any pending upper-half write are out
            RUN:     if (last_seen && !pend) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        accept    = (state == RUN) && in_valid && !last_seen;
        seq_addr  = base + ADDR_W'((order == ORD_REV) ? bitrev(k) : k);
        pair_addr = base + ADDR_W'(k >> 1);
        busy      = (state == RUN);
        done      = (state == FIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            order     <= ORD_NAT;
            base      <= '0;
            k         <= '0;
            last_seen <= 1'b0;
            pend      <= 1'b0;
            hold      <= '0;
            pend_data <= '0;
            pend_addr <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            state <= state_nxt;
            wr_en <= 1'b0;
            if (state == IDLE && start) begin
                case (mode)
                    2'd1:    order <= ORD_REV;
                    2'd2:    order <= ORD_DEI;
                    default: order <= ORD_NAT;
                endcase
                base      <= base_addr;
                k         <= '0;
                last_seen <= 1'b0;
                pend      <= 1'b0;
            end
            if (state == RUN && pend) begin
                wr_en   <= 1'b1;
                wr_addr <= pend_addr;
                wr_data <= pend_data;
                pend    <= 1'b0;
            end
            // an even de-interleave beat may arrive alongside the pending write; it is only buffered
            if (accept) begin
                k <= k + 1'b1;
                if (k == LAST) last_seen <= 1'b1;
                if (order == ORD_DEI) begin
                    if (!k[0]) begin
                        hold <= result;
                    end else begin
                        wr_en     <= 1'b1;
                        wr_addr   <= pair_addr;
                        wr_data   <= {result[HW-1:0], hold[HW-1:0]};
                        pend      <= 1'b1;
                        pend_addr <= pair_addr + HALF;
                        pend_data <= {result[DW-1:HW], hold[DW-1:HW]};
                    end
                end else begin
                    wr_en   <= 1'b1;
                    wr_addr <= seq_addr;
                    wr_data <= result;
                end
            end
        end
    end
endmodule

// File: tb/tb_poly_result_writer.sv
// Self-checking bench for poly_result_writer: table of transfers with spot checks,
// full write sequences compared against an arithmetic model, plus reset sequences.
module tb_poly_result_writer;
    localparam int COEF_W  = 64;
    localparam int LANES   = 2;
    localparam int ADDR_W  = 10;
    localparam int N_WORDS = 256;
    localparam int LOG_N   = 8;
    localparam int DW      = LANES * COEF_W;
    localparam int HW      = DW / 2;
    localparam int CAP     = N_WORDS + 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [1:0]        mode;
    logic [ADDR_W-1:0] base_addr;
    logic              in_valid;
    logic [DW-1:0]     result;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DW-1:0]     wr_data;
    logic              busy;
    logic              done;

    always #5 clk = ~clk;

    poly_result_writer #(
        .COEF_W(COEF_W), .LANES(LANES), .ADDR_W(ADDR_W), .N_WORDS(N_WORDS), .LOG_N(LOG_N)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .base_addr(base_addr),
        .in_valid(in_valid), .result(result), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .busy(busy), .done(done)
    );

    typedef struct {
        int                mode;
        int                base;
        int                pat;
        int                duty;
        bit                start_busy;
        bit                iv_at_start;
        int                idx;
        logic [ADDR_W-1:0] addr;
        logic [DW-1:0]     data;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [DW-1:0]     beats  [N_WORDS];
    logic [ADDR_W-1:0] m_addr [N_WORDS];
    logic [DW-1:0]     m_data [N_WORDS];
    logic [ADDR_W-1:0] cap_addr [CAP];
    logic [DW-1:0]     cap_data [CAP];
    int                ncap;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] v;
        for (int b = 0; b < DW; b += 32) v[b +: 32] = $urandom();
        return v;
    endfunction

    function automatic logic [DW-1:0] make_beat(input int pat, input int k);
        logic [DW-1:0] v;
        v = '0;
        for (int r = 0; r < LANES; r++) begin
            if (pat == 0)      v[r*COEF_W +: COEF_W] = COEF_W'(k);
            else if (pat == 1) v[r*COEF_W +: COEF_W] = COEF_W'((r < LANES/2) ? 'hA000 + k : 'hB000 + k);
        end
        if (pat == 2) v = rand_word();
        return v;
    endfunction

    // Expected write list from the ordering rules, using plain integer arithmetic.
    task automatic build_model(input int m, input int base);
        int rev;
        for (int k = 0; k < N_WORDS; k++) begin
            rev = 0;
            for (int i = 0; i < LOG_N; i++) rev = (rev << 1) | ((k >> i) & 1);
            if (m == 1) begin
                m_addr[k] = ADDR_W'((base + rev) % (1 << ADDR_W));
                m_data[k] = beats[k];
            end else if (m == 2) begin
                if (k % 2 == 0) begin
                    m_addr[k] = ADDR_W'((base + k/2) % (1 << ADDR_W));
                    m_data[k] = {beats[k+1][HW-1:0], beats[k][HW-1:0]};
                end else begin
                    m_addr[k] = ADDR_W'((base + N_WORDS/2 + k/2) % (1 << ADDR_W));
                    m_data[k] = {beats[k][DW-1:HW], beats[k-1][DW-1:HW]};
                end
            end else begin
                m_addr[k] = ADDR_W'((base + k) % (1 << ADDR_W));
                m_data[k] = beats[k];
            end
        end
    endtask

    task automatic run_transfer(input vec_t v, input int row);
        int k, busy_cnt, done_cnt, done_cyc, last_wr, exp_busy;
        for (int i = 0; i < N_WORDS; i++) beats[i] = make_beat(v.pat, i);
        build_model(v.mode, v.base);
        @(negedge clk);
        start     = 1'b1;
        mode      = 2'(v.mode);
        base_addr = ADDR_W'(v.base);
        in_valid  = v.iv_at_start;
        result    = rand_word();
        ncap = 0; k = 0; busy_cnt = 0; done_cnt = 0; done_cyc = -1; last_wr = -1;
        for (int cyc = 1; cyc < 4000 && !(done_cnt > 0 && cyc > done_cyc + 2); cyc++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (wr_en) begin
                if (ncap < CAP) begin
                    cap_addr[ncap] = wr_addr;
                    cap_data[ncap] = wr_data;
                end
                ncap++;
                last_wr = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            start     = v.start_busy && (cyc == 50);
            mode      = 2'($urandom_range(3));
            base_addr = ADDR_W'($urandom());
            if (cyc >= 2 && k < N_WORDS && $urandom_range(99) < v.duty) begin
                in_valid = 1'b1;
                result   = beats[k];
                k++;
            end else begin
                in_valid = 1'b0;
                result   = rand_word();
            end
        end
        start    = 1'b0;
        in_valid = 1'b0;
        check($sformatf("r%0d nwrites", row), DW'(ncap), DW'(N_WORDS));
        for (int i = 0; i < N_WORDS && i < ncap; i++) begin
            check($sformatf("r%0d addr[%0d]", row, i), DW'(cap_addr[i]), DW'(m_addr[i]));
            check($sformatf("r%0d data[%0d]", row, i), cap_data[i], m_data[i]);
        end
        check($sformatf("r%0d done_count", row), DW'(done_cnt), DW'(1));
        check($sformatf("r%0d done_after_last_write", row), DW'(done_cyc), DW'(last_wr + 1));
        if (v.duty == 100 && !v.start_busy) begin
            exp_busy = N_WORDS + 2 + ((v.mode == 2) ? 1 : 0);
            check($sformatf("r%0d busy_cycles", row), DW'(busy_cnt), DW'(exp_busy));
        end
    endtask

    task automatic add(input int m, input int b, input int pat, input int duty, input bit sb,
                       input bit ivs, input int idx, input int addr, input logic [DW-1:0] data);
        vec_t v;
        v.mode = m; v.base = b; v.pat = pat; v.duty = duty; v.start_busy = sb;
        v.iv_at_start = ivs; v.idx = idx; v.addr = ADDR_W'(addr); v.data = data;
        vecs.push_back(v);
    endtask

    initial begin
        int stray;
        add(0, 'h100, 0, 100, 0, 0,   0, 'h100, {64'd0,   64'd0});
        add(0, 'h100, 0, 100, 0, 0, 255, 'h1FF, {64'd255, 64'd255});
        add(1, 0,     0, 100, 0, 0,   1, 'h080, {64'd1,   64'd1});
        add(1, 0,     0, 100, 0, 0,   2, 'h040, {64'd2,   64'd2});
        add(1, 0,     0, 100, 0, 0, 255, 'h0FF, {64'd255, 64'd255});
        add(2, 0,     1, 100, 0, 0,   0, 0,     {64'hA001, 64'hA000});
        add(2, 0,     1, 100, 0, 0,   1, 128,   {64'hB001, 64'hB000});
        add(2, 0,     1, 100, 0, 0, 254, 127,   {64'hA0FF, 64'hA0FE});
        add(2, 0,     1, 100, 0, 0, 255, 255,   {64'hB0FF, 64'hB0FE});
        add(2, 0,     1,  30, 1, 1,   1, 128,   {64'hB001, 64'hB000});
        add(0, 'h3F0, 0, 100, 0, 0,  16, 0,     {64'd16,  64'd16});
        add(3, 'h020, 2,  50, 0, 1,  -1, 0,     '0);
        add(1, 'h155, 2,  60, 1, 0,  -1, 0,     '0);

        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; mode = '0; base_addr = '0; result = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("reset_outputs c%0d", c), DW'({wr_en, busy, done, wr_addr}), '0);
            start    = ~start;
            in_valid = ~in_valid;
        end
        @(negedge clk);
        check("reset_wr_data", wr_data, '0);
        rst_n = 1'b1; start = 1'b0; in_valid = 1'b0;

        // Abort mid-run at beat 100.
        @(negedge clk);
        start = 1'b1; mode = 2'd0; base_addr = '0;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k <= 100; k++) begin
            in_valid = 1'b1;
            result   = make_beat(0, k);
            if (k < 100) @(negedge clk);
        end
        @(posedge clk);
        #1;
        check("abort_wr_en_before", DW'(wr_en), DW'(1));
        rst_n = 1'b0;
        #1;
        check("abort_wr_en_busy", DW'({wr_en, busy}), '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (wr_en || done) stray++;
            in_valid = ~in_valid;
            result   = rand_word();
        end
        in_valid = 1'b0;
        check("abort_no_writes", DW'(stray), '0);

        foreach (vecs[i]) begin
            run_transfer(vecs[i], i);
            if (vecs[i].idx >= 0) begin
                check($sformatf("row%0d spot_addr", i), DW'(cap_addr[vecs[i].idx]), DW'(vecs[i].addr));
                check($sformatf("row%0d spot_data", i), cap_data[vecs[i].idx], vecs[i].data);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
